// File: rtl/wb_select_buffer.sv
// wb_select_buffer
//   Writeback-select stage between MEM and the register-file write port.
//   It picks the writeback value from one of four sources: ALU result,
//   extended load lane, link address (pc + PC_INC) or immediate. The value,
//   rd_addr and rd_we then pass through a 2-entry valid/ready skid buffer.
//   The block also counts pops that carry a register write.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   in_valid / in_ready        upstream handshake (push)
//   sel                        0 ALU, 1 MEM, 2 pc+PC_INC, 3 imm
//   load_size                  0 byte, 1 half, 2/3 word
//   load_unsigned              1 zero-extend, 0 sign-extend
//   byte_off                   load address bits [1:0]
//   alu_result, mem_data, pc, imm   candidate sources
//   rd_addr, rd_we             destination register and write enable
//   out_valid / out_ready      downstream handshake (pop)
//   out_data, out_rd_addr, out_rd_we   head entry
//   retire_cnt                 pops with out_rd_we=1, wraps
module wb_select_buffer #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int PC_INC = 4,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] rd;
    logic              we;
  } ent_t;

  state_e           state_q, state_d;
  ent_t [1:0]       ent_q, ent_d;
  logic             hd_q, hd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push, pop, wr_idx;
  ent_t             head, new_ent;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic             fill;
  logic [DATA_W-1:0] ld_val, wb_val;

  // ---------------------------------------------------------------------
  // Load lane extraction. Fill the whole word with the extension bit
  // first, then overwrite the low lane. This avoids a zero-width
  // replication when DATA_W == 32.
  // ---------------------------------------------------------------------
  always_comb begin
    ld_b = 8'h00;
    unique case (byte_off)
      2'd0: ld_b = mem_data[7:0];
      2'd1: ld_b = mem_data[15:8];
      2'd2: ld_b = mem_data[23:16];
      default: ld_b = mem_data[31:24];
    endcase
  end

  // byte_off[0] is ignored for halves: the lane is picked by bit 1 only.
  assign ld_h = byte_off[1] ? mem_data[31:16] : mem_data[15:0];

  always_comb begin
    fill   = 1'b0;
    ld_val = '0;
    unique case (load_size)
      2'd0: begin
        fill        = ~load_unsigned & ld_b[7];
        ld_val      = {DATA_W{fill}};
        ld_val[7:0] = ld_b;
      end
      2'd1: begin
        fill         = ~load_unsigned & ld_h[15];
        ld_val       = {DATA_W{fill}};
        ld_val[15:0] = ld_h;
      end
      default: begin
        fill         = ~load_unsigned & mem_data[31];
        ld_val       = {DATA_W{fill}};
        ld_val[31:0] = mem_data[31:0];
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Source select. The link address wraps modulo 2^DATA_W.
  // ---------------------------------------------------------------------
  always_comb begin
    wb_val = alu_result;
    unique case (sel)
      2'd0: wb_val = alu_result;
      2'd1: wb_val = ld_val;
      2'd2: wb_val = DATA_W'(pc) + DATA_W'(PC_INC);
      default: wb_val = imm;
    endcase
  end

  assign new_ent = '{data: wb_val, rd: rd_addr, we: rd_we};

  // ---------------------------------------------------------------------
  // Handshakes. in_ready is forced low during reset, so nothing is
  // accepted while rst_n is low.
  // ---------------------------------------------------------------------
  assign in_ready  = rst_n && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head        = ent_q[hd_q];
  assign out_data    = head.data;
  assign out_rd_addr = head.rd;
  assign out_rd_we   = head.we;
  assign retire_cnt  = cnt_q;

  // When EMPTY, the tail slot is the head slot. Otherwise it is the other
  // slot. A push is never accepted while FULL.
  assign wr_idx = (state_q == EMPTY) ? hd_q : ~hd_q;

  // ---------------------------------------------------------------------
  // Occupancy FSM and datapath next state.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
        else                   state_d = ONE;
      end
      FULL: if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ent_d = ent_q;
    if (push) ent_d[wr_idx] = new_ent;
    // A pop moves the head to the other slot. When ONE pushes and pops in
    // the same cycle, that slot holds the entry written this cycle.
    hd_d  = pop ? ~hd_q : hd_q;
    cnt_d = cnt_q;
    if (pop && head.we) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ent_q   <= '0;
      hd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      hd_q    <= hd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
